// File: rtl/instr_encoder_if.sv
// Request and program-memory write bundle for instr_encoder.
// slave is the encoder's view; master is the requester/memory side.
interface instr_encoder_if;
    localparam int unsigned AW = 32;
    localparam int unsigned WW = 32;
    localparam int unsigned CW = 16;

    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_kind;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic          mem_we;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic [CW-1:0] words_written;
    logic          err;

    modport slave (
        input  req_valid, req_kind, rs, rt, rd, shamt, funct, imm, mem_ready,
        output req_ready, mem_we, mem_addr, mem_wdata, words_written, err
    );

    modport master (
        output req_valid, req_kind, rs, rt, rd, shamt, funct, imm, mem_ready,
        input  req_ready, mem_we, mem_addr, mem_wdata, words_written, err
    );
endinterface

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder feeding program memory through a 2-entry FIFO.
// Define INSTR_ENCODER_BRANCH_EN to encode BEQ/BNE; otherwise they flag err.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    instr_encoder_if.slave bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned WW = 32;
    localparam int unsigned CW = 16;

    logic [WW-1:0] d0_q, d0_d, d1_q, d1_d;
    logic          v0_q, v0_d, v1_q, v1_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [WW-1:0] word_c;
    logic          ok_c;
    logic          accept;
    logic          push;
    logic          pop;

    // Field packing per request kind; ok_c low marks an unsupported kind.
    always_comb begin
        word_c = '0;
        ok_c   = 1'b1;
        case (bus.req_kind)
            3'd0: word_c = {6'h00, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            3'd1: word_c = {6'h08, bus.rs, bus.rt, bus.imm};
            3'd2: word_c = {6'h0d, bus.rs, bus.rt, bus.imm};
            3'd3: word_c = {6'h0f, 5'd0, bus.rt, bus.imm};
            3'd4: word_c = {6'h23, bus.rs, bus.rt, bus.imm};
            3'd5: word_c = {6'h2b, bus.rs, bus.rt, bus.imm};
`ifdef INSTR_ENCODER_BRANCH_EN
            3'd6: word_c = {6'h04, bus.rs, bus.rt, bus.imm};
            3'd7: word_c = {6'h05, bus.rs, bus.rt, bus.imm};
`else
            3'd6: ok_c = 1'b0;
            3'd7: ok_c = 1'b0;
`endif
            default: ok_c = 1'b0;
        endcase
    end

    assign bus.req_ready = !v1_q && !restart && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = accept && ok_c;
    assign pop           = v0_q && bus.mem_ready;

    // Shift FIFO: slot 0 is always the head driven onto the memory port.
    always_comb begin
        d0_d   = d0_q;
        d1_d   = d1_q;
        v0_d   = v0_q;
        v1_d   = v1_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        err_d  = err_q;

        if (pop) begin
            addr_d = addr_q + AW'(4);
            cnt_d  = cnt_q + CW'(1);
        end
        if (accept && !ok_c) begin
            err_d = 1'b1;
        end

        case ({push, pop})
            2'b01: begin
                d0_d = d1_q;
                v0_d = v1_q;
                v1_d = 1'b0;
            end
            2'b10: begin
                if (!v0_q) begin
                    d0_d = word_c;
                    v0_d = 1'b1;
                end else begin
                    d1_d = word_c;
                    v1_d = 1'b1;
                end
            end
            2'b11: begin
                if (v1_q) begin
                    d0_d = d1_q;
                    d1_d = word_c;
                end else begin
                    d0_d = word_c;
                end
            end
            default: ;
        endcase

        // Flush wins over any write completing this cycle.
        if (restart) begin
            d0_d   = '0;
            d1_d   = '0;
            v0_d   = 1'b0;
            v1_d   = 1'b0;
            addr_d = BASE_ADDR;
            cnt_d  = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d0_q   <= '0;
            d1_q   <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            addr_q <= BASE_ADDR;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            d0_q   <= d0_d;
            d1_q   <= d1_d;
            v0_q   <= v0_d;
            v1_q   <= v1_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign bus.mem_we        = v0_q;
    assign bus.mem_wdata     = d0_q;
    assign bus.mem_addr      = addr_q;
    assign bus.words_written = cnt_q;
    assign bus.err           = err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0040_0000: byte address of first program word written.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-004 SHALL have port restart  input  1: synchronous flush; restarts the write address at BASE_ADDR.
REQ-005 SHALL have port req_valid  input  1: encode request present.
REQ-006 SHALL have port req_ready  output  1: request accepted when req_valid and req_ready are both high.
REQ-007 SHALL have port req_kind  input  3: 0 R-type, 1 ADDI, 2 ORI, 3 LUI, 4 LW, 5 SW, 6 BEQ, 7 BNE.
REQ-008 SHALL have ports rs, rt, rd, shamt  input  5 each; funct  input  6; imm  input  16: instruction fields.
REQ-009 SHALL have port mem_we  output  1: program-memory write strobe, which also serves as the valid signal.
REQ-010 SHALL have port mem_ready  input  1: memory accepts the word when mem_we and mem_ready are both high.
REQ-011 SHALL have ports mem_addr  output  32 and mem_wdata  output  32: write address and encoded word.
REQ-012 SHALL have ports words_written  output  16 and err  output  1: count of completed writes and sticky unsupported-kind flag.

Function
REQ-013 SHALL encode R-type as {6'h00, rs, rt, rd, shamt, funct}.
REQ-014 SHALL encode the other kinds as {op, rs, rt, imm}: ADDI 6'h08, ORI 6'h0d, LUI 6'h0f (rs forced 0), LW 6'h23, SW 6'h2b, BEQ 6'h04, BNE 6'h05.
REQ-015 SHALL buffer encoded words in a 2-entry FIFO; req_ready = FIFO not full and restart low.
REQ-016 SHALL present an accepted word on mem_wdata, with mem_we high, in the cycle after acceptance when the FIFO was empty; there is no combinational req-to-mem path.
REQ-017 SHALL drive mem_we = FIFO not empty, with mem_wdata = FIFO head; mem_wdata is held stable while mem_we is high and mem_ready is low.
REQ-018 SHALL, on each completed write, pop the FIFO, add 4 to mem_addr (32-bit wrap from 32'hFFFF_FFFC to 0) and add 1 to words_written (16-bit wrap).
REQ-019 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged.
REQ-020 SHALL not push when full; req_ready low is the only back-pressure mechanism.
REQ-021 SHALL consume an unsupported kind (req_ready high), write nothing to the FIFO and set err; err stays set until reset or restart.
REQ-022 SHALL, on restart, empty the FIFO, set mem_addr to BASE_ADDR, and clear words_written and err in the next cycle; a write completing in the same cycle is discarded and not counted.

Reset
REQ-023 SHALL, in the cycle after reset is high at a clock edge, drive mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, words_written=0, err=0, with the FIFO empty.
REQ-024 SHALL hold req_ready=0 while reset is high; reset takes priority over restart and over all traffic, including mid-write.

Configuration
REQ-025 SHALL, with macro INSTR_ENCODER_BRANCH_EN defined, encode kinds 6 (BEQ) and 7 (BNE) per REQ-014.
REQ-026 SHALL, without INSTR_ENCODER_BRANCH_EN, treat kinds 6 and 7 as unsupported per REQ-021.

Verification
REQ-027 SHALL cover: after reset, ADDI rs=0 rt=8 imm=0x0005, mem_ready=1 -> next cycle mem_we=1, addr 0x00400000, data 0x20080005; then words_written=1.
REQ-028 SHALL cover: R rs=9 rt=10 rd=8 shamt=0 funct=0x20, then LW rs=29 rt=8 imm=4, then SW rs=29 rt=8 imm=8 -> 0x012A4020 @0x00400000, 0x8FA80004 @0x00400004, 0xAFA80008 @0x00400008.
REQ-029 SHALL cover: mem_ready=0, three back-to-back requests LUI rt=1 imm=0x1001, ORI rs=1 rt=1 imm=0x0010, ADDI -> req_ready low after 2 accepts, mem_wdata held at 0x3C011001; after release, 0x34210010 follows in order.
REQ-030 SHALL cover: BEQ rs=8 rt=9 imm=3 and BNE with the same fields -> 0x11090003 and 0x15090003 with the macro defined; with it undefined -> err=1 and no mem_we.
REQ-031 SHALL cover: restart asserted with 2 words queued and mem_ready=1 -> next cycle mem_we=0, mem_addr=0x00400000, words_written=0, err=0.
REQ-032 SHALL cover: BASE_ADDR=32'hFFFF_FFFC, two writes -> addresses 0xFFFFFFFC then 0x00000000.
